// File: rtl/fp_sum_seq.sv
// fp_sum_seq: drives an external FP32 add/sub unit to accumulate a stream of terms,
// returning the series sum with sticky overflow and add_done timeout status.
module fp_sum_seq #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      term_in,
   input  logic             term_valid,
   input  logic             term_last,
   output logic             term_ready,
   output logic [31:0]      add_op1,
   output logic [31:0]      add_op2,
   output logic             add_start,
   input  logic [31:0]      add_result,
   input  logic             add_done,
   input  logic             add_overflow,
   output logic [31:0]      sum_result,
   output logic             sum_valid,
   input  logic             sum_ack,
   output logic             sum_overflow,
   output logic             sum_timeout,
   output logic [CNT_W-1:0] term_count,
   output logic             busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t        state;
   logic [31:0]   acc;
   logic [31:0]   term;
   logic          last;
   logic [TW-1:0] wait_cnt;

   assign term_ready = (state == S_IDLE) || (state == S_COLLECT);
   assign busy       = (state != S_IDLE);
   assign add_op1    = acc;
   assign add_op2    = term;

   // wait_cnt holds k-1 in the k-th WAIT cycle, so the TIMEOUT_CYCLES-th
   // cycle without add_done aborts while a done in that same cycle still wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         acc          <= '0;
         term         <= '0;
         last         <= 1'b0;
         wait_cnt     <= '0;
         add_start    <= 1'b0;
         sum_result   <= '0;
         sum_valid    <= 1'b0;
         sum_overflow <= 1'b0;
         sum_timeout  <= 1'b0;
         term_count   <= '0;
      end else begin
         add_start <= 1'b0;
         case (state)
            S_IDLE, S_COLLECT: begin
               if (term_valid) begin
                  term      <= term_in;
                  last      <= term_last;
                  add_start <= 1'b1;
                  state     <= S_ISSUE;
                  if (state == S_IDLE) begin
                     acc          <= '0;
                     term_count   <= '0;
                     sum_overflow <= 1'b0;
                     sum_timeout  <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (add_done) begin
                  acc          <= add_result;
                  sum_overflow <= sum_overflow | add_overflow;
                  if (term_count != '1) term_count <= term_count + 1'b1;
                  if (last) begin
                     sum_result <= add_result;
                     sum_valid  <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     state <= S_COLLECT;
                  end
               end else if (wait_cnt == WAIT_LIMIT) begin
                  sum_timeout <= 1'b1;
                  sum_result  <= acc;
                  sum_valid   <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (sum_ack) begin
                  sum_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sum_seq.sv
// tb_fp_sum_seq: exercises fp_sum_seq against an in-bench addsub model with programmable
// done delay, comparing results to a real-arithmetic reference of the series sum.
`timescale 1ns/1ps
module tb_fp_sum_seq;

   localparam int TOUT = 16;
   localparam int CW   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   term_in = '0;
   logic          term_valid = 1'b0;
   logic          term_last = 1'b0;
   logic          term_ready;
   logic [31:0]   add_op1, add_op2;
   logic          add_start;
   logic [31:0]   add_result;
   logic          add_done;
   logic          add_overflow;
   logic [31:0]   sum_result;
   logic          sum_valid;
   logic          sum_ack = 1'b0;
   logic          sum_overflow, sum_timeout;
   logic [CW-1:0] term_count;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int model_delay = 1;
   int ovf_on_issue = 0;
   int hang_on_issue = 0;
   int issue_count = 0;
   int ready_in_wait = 0;
   bit pending = 1'b0;
   int wait_left = 0;
   bit m_ovf, m_hang;
   logic [31:0] m_op1, m_op2;
   logic [31:0] op1_q[$];
   logic [31:0] op2_q[$];
   int start_cyc[$];
   logic [31:0] tq[$];

   fp_sum_seq #(.TIMEOUT_CYCLES(TOUT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .term_in(term_in), .term_valid(term_valid), .term_last(term_last), .term_ready(term_ready),
      .add_op1(add_op1), .add_op2(add_op2), .add_start(add_start),
      .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
      .sum_result(sum_result), .sum_valid(sum_valid), .sum_ack(sum_ack),
      .sum_overflow(sum_overflow), .sum_timeout(sum_timeout),
      .term_count(term_count), .busy(busy)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic real fp32_to_real(input logic [31:0] b);
      logic [63:0] d;
      if (b[30:0] == 31'd0) d = {b[31], 63'd0};
      else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real_to_fp32(input real r);
      logic [63:0] d;
      logic [24:0] m;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      m = {2'b01, d[51:29]};
      if (d[28] && ((d[27:0] != 28'd0) || d[29])) m = m + 25'd1;
      e = d[62:52];
      if (m[24]) begin
         m = m >> 1;
         e = e + 11'd1;
      end
      return {d[63], 8'(e - 11'd896), m[22:0]};
   endfunction

   // Reference: sum of the first n queued terms, done in real arithmetic.
   function automatic logic [31:0] ref_sum(input int n);
      real s;
      s = 0.0;
      for (int i = 0; i < n; i++) s = s + fp32_to_real(tq[i]);
      return real_to_fp32(s);
   endfunction

   function automatic logic [31:0] rand_term();
      int v;
      v = int'($urandom_range(0, 200)) - 100;
      if (v == 0) v = 7;
      return real_to_fp32(real'(v));
   endfunction

   function automatic logic [31:0] op1_at(input int i);
      return (i < op1_q.size()) ? op1_q[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] op2_at(input int i);
      return (i < op2_q.size()) ? op2_q[i] : 32'hxxxx_xxxx;
   endfunction

   // Behavioural addsub unit: done arrives on the model_delay-th WAIT cycle.
   initial begin
      add_done = 1'b0;
      add_overflow = 1'b0;
      add_result = '0;
      forever begin
         @(negedge clk);
         add_done = 1'b0;
         add_overflow = 1'b0;
         if ((pending || add_start) && term_ready) ready_in_wait++;
         if (add_start) begin
            issue_count++;
            op1_q.push_back(add_op1);
            op2_q.push_back(add_op2);
            start_cyc.push_back(cyc);
            m_op1 = add_op1;
            m_op2 = add_op2;
            wait_left = model_delay;
            m_ovf = (issue_count == ovf_on_issue);
            m_hang = (issue_count == hang_on_issue);
            pending = 1'b1;
         end else if (pending) begin
            wait_left--;
            if (wait_left == 0) begin
               pending = 1'b0;
               if (!m_hang) begin
                  add_done = 1'b1;
                  add_result = real_to_fp32(fp32_to_real(m_op1) + fp32_to_real(m_op2));
                  add_overflow = m_ovf;
               end
            end
         end
      end
   end

   task automatic clear_model();
      op1_q.delete();
      op2_q.delete();
      start_cyc.delete();
      issue_count = 0;
      ready_in_wait = 0;
   endtask

   // Presents every queued term back to back with term_valid held high.
   task automatic drive_series(output bit ok);
      int n;
      ok = 1'b1;
      for (int i = 0; i < tq.size(); i++) begin
         term_in = tq[i];
         term_last = (i == tq.size() - 1);
         term_valid = 1'b1;
         n = 0;
         while (!term_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!term_ready) begin
            ok = 1'b0;
            break;
         end
         @(negedge clk);
      end
      term_valid = 1'b0;
      term_last = 1'b0;
   endtask

   task automatic wait_sum(output bit ok, output int at);
      int n;
      n = 0;
      while (!sum_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = sum_valid;
      at = cyc;
   endtask

   task automatic ack_sum();
      sum_ack = 1'b1;
      @(negedge clk);
      sum_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({busy, term_ready, add_start, sum_valid} !== 4'b0100) begin errors++; $display("[TB] FAIL reset_ctrl: got %b want 0100", {busy, term_ready, add_start, sum_valid}); end
      checks++; if ({add_op1, add_op2, sum_result} !== 96'd0) begin errors++; $display("[TB] FAIL reset_data: got %h %h %h want zeros", add_op1, add_op2, sum_result); end
      checks++; if ({term_count, sum_overflow, sum_timeout} !== 10'd0) begin errors++; $display("[TB] FAIL reset_status: got %h %b %b want 0", term_count, sum_overflow, sum_timeout); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || term_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got busy %b ready %b want 0 1", busy, term_ready); end
   endtask

   task automatic test_single();
      bit ok;
      int at;
      clear_model();
      model_delay = 1; ovf_on_issue = 0; hang_on_issue = 0;
      tq = {32'h4020_0000};
      drive_series(ok);
      wait_sum(ok, at);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL single_wait: sum_valid got 0 want 1"); end
      checks++; if (op1_at(0) !== 32'h0 || op2_at(0) !== 32'h4020_0000) begin errors++; $display("[TB] FAIL single_ops: got %h %h want 00000000 40200000", op1_at(0), op2_at(0)); end
      checks++; if (issue_count != 1) begin errors++; $display("[TB] FAIL single_starts: got %0d want 1", issue_count); end
      checks++; if (sum_result !== 32'h4020_0000 || term_count !== 8'd1) begin errors++; $display("[TB] FAIL single_sum: got %h cnt %0d want 40200000 cnt 1", sum_result, term_count); end
      ack_sum();
      checks++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_ack: got valid %b busy %b want 0 0", sum_valid, busy); end
   endtask

   task automatic test_three();
      bit ok;
      int at;
      clear_model();
      model_delay = 2; ovf_on_issue = 0; hang_on_issue = 0;
      tq = {32'h4020_0000, 32'h4060_0000, 32'hC0C0_0000};
      drive_series(ok);
      wait_sum(ok, at);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL three_wait: sum_valid got 0 want 1"); end
      checks++; if (op1_at(1) !== 32'h4020_0000 || op1_at(2) !== 32'h40C0_0000) begin errors++; $display("[TB] FAIL three_acc: got %h %h want 40200000 40c00000", op1_at(1), op1_at(2)); end
      checks++; if (sum_result !== 32'h0 || term_count !== 8'd3) begin errors++; $display("[TB] FAIL three_sum: got %h cnt %0d want 00000000 cnt 3", sum_result, term_count); end
      ack_sum();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int at;
      clear_model();
      model_delay = 5; ovf_on_issue = 0; hang_on_issue = 0;
      tq = {rand_term(), rand_term(), rand_term()};
      drive_series(ok);
      wait_sum(ok, at);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_wait: sum_valid got 0 want 1"); end
      checks++; if (ready_in_wait != 0) begin errors++; $display("[TB] FAIL b2b_ready: ready-while-busy cycles got %0d want 0", ready_in_wait); end
      checks++; if (issue_count != 3) begin errors++; $display("[TB] FAIL b2b_starts: got %0d want 3", issue_count); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (op2_at(i) !== tq[i]) begin errors++; $display("[TB] FAIL b2b_term%0d: got %h want %h", i, op2_at(i), tq[i]); end
      end
      checks++; if (sum_result !== ref_sum(3) || term_count !== 8'd3) begin errors++; $display("[TB] FAIL b2b_sum: got %h cnt %0d want %h cnt 3", sum_result, term_count, ref_sum(3)); end
      ack_sum();
   endtask

   task automatic test_overflow();
      bit ok;
      int at;
      clear_model();
      model_delay = 1; ovf_on_issue = 2; hang_on_issue = 0;
      tq = {rand_term(), rand_term(), rand_term()};
      drive_series(ok);
      wait_sum(ok, at);
      checks++; if (!ok || sum_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done: got valid %b ovf %b want 1 1", sum_valid, sum_overflow); end
      ack_sum();
      repeat (2) @(negedge clk);
      checks++; if (sum_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_held: got %b want 1", sum_overflow); end
      clear_model();
      ovf_on_issue = 0;
      tq = {rand_term()};
      drive_series(ok);
      checks++; if (sum_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b want 0", sum_overflow); end
      wait_sum(ok, at);
      checks++; if (!ok || sum_result !== ref_sum(1)) begin errors++; $display("[TB] FAIL ovf_next_sum: got %h want %h", sum_result, ref_sum(1)); end
      ack_sum();
   endtask

   task automatic test_timeout();
      bit ok;
      int at;
      clear_model();
      model_delay = 2; ovf_on_issue = 0; hang_on_issue = 2;
      tq = {32'h4020_0000, 32'h4060_0000};
      drive_series(ok);
      wait_sum(ok, at);
      checks++; if (!ok || sum_timeout !== 1'b1) begin errors++; $display("[TB] FAIL tout_flag: got valid %b tout %b want 1 1", sum_valid, sum_timeout); end
      checks++; if (start_cyc.size() != 2 || at - start_cyc[start_cyc.size()-1] != TOUT + 1) begin errors++; $display("[TB] FAIL tout_latency: got %0d cycles want %0d", at - start_cyc[start_cyc.size()-1], TOUT + 1); end
      checks++; if (sum_result !== 32'h4020_0000 || term_count !== 8'd1) begin errors++; $display("[TB] FAIL tout_sum: got %h cnt %0d want 40200000 cnt 1", sum_result, term_count); end
      ack_sum();
      checks++; if (sum_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL tout_held: got tout %b busy %b want 1 0", sum_timeout, busy); end
   endtask

   task automatic test_expiry_boundary();
      bit ok;
      int at;
      clear_model();
      model_delay = TOUT; ovf_on_issue = 0; hang_on_issue = 0;
      tq = {rand_term()};
      drive_series(ok);
      wait_sum(ok, at);
      checks++; if (!ok || sum_timeout !== 1'b0) begin errors++; $display("[TB] FAIL edge_done_wins: got valid %b tout %b want 1 0", sum_valid, sum_timeout); end
      checks++; if (sum_result !== ref_sum(1) || term_count !== 8'd1) begin errors++; $display("[TB] FAIL edge_sum: got %h cnt %0d want %h cnt 1", sum_result, term_count, ref_sum(1)); end
      ack_sum();
      clear_model();
      model_delay = TOUT + 1;
      drive_series(ok);
      wait_sum(ok, at);
      checks++; if (!ok || sum_timeout !== 1'b1) begin errors++; $display("[TB] FAIL edge_late_tout: got valid %b tout %b want 1 1", sum_valid, sum_timeout); end
      repeat (3) @(negedge clk);
      checks++; if (sum_result !== 32'h0 || term_count !== 8'd0 || sum_valid !== 1'b1) begin errors++; $display("[TB] FAIL edge_late_ignored: got %h cnt %0d valid %b want 0 0 1", sum_result, term_count, sum_valid); end
      ack_sum();
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      clear_model();
      model_delay = 6; ovf_on_issue = 0; hang_on_issue = 0;
      tq = {32'h4020_0000};
      drive_series(ok);
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1 || term_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstw_in_wait: got busy %b ready %b want 1 0", busy, term_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || term_ready !== 1'b1 || add_op2 !== 32'h0 || term_count !== 8'd0) begin errors++; $display("[TB] FAIL rstw_state: got busy %b ready %b op2 %h cnt %0d want 0 1 0 0", busy, term_ready, add_op2, term_count); end
      repeat (8) @(negedge clk);
      checks++; if (busy !== 1'b0 || sum_valid !== 1'b0 || add_op1 !== 32'h0 || term_count !== 8'd0) begin errors++; $display("[TB] FAIL rstw_late_done: got busy %b valid %b acc %h cnt %0d want 0 0 0 0", busy, sum_valid, add_op1, term_count); end
   endtask

   task automatic test_random();
      bit ok;
      int at;
      int len;
      for (int s = 0; s < 4; s++) begin
         clear_model();
         len = int'($urandom_range(1, 4));
         model_delay = int'($urandom_range(1, 8));
         ovf_on_issue = int'($urandom_range(0, len));
         hang_on_issue = 0;
         tq.delete();
         for (int i = 0; i < len; i++) tq.push_back(rand_term());
         drive_series(ok);
         wait_sum(ok, at);
         checks++; if (!ok || sum_result !== ref_sum(len)) begin errors++; $display("[TB] FAIL rand%0d_sum: got %h want %h", s, sum_result, ref_sum(len)); end
         checks++; if (term_count !== CW'(len) || sum_overflow !== (ovf_on_issue != 0) || sum_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_status: got cnt %0d ovf %b tout %b want %0d %b 0", s, term_count, sum_overflow, sum_timeout, len, ovf_on_issue != 0); end
         for (int i = 0; i < len; i++) begin
            checks++; if (op1_at(i) !== ref_sum(i) || op2_at(i) !== tq[i]) begin errors++; $display("[TB] FAIL rand%0d_ops%0d: got %h %h want %h %h", s, i, op1_at(i), op2_at(i), ref_sum(i), tq[i]); end
         end
         ack_sum();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_three();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_expiry_boundary();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
